// File: rtl/nic_flit_injector_pkg.sv
// Shared constants for the NIC injection port: link geometry, channel/flow-control field offsets, FSM encodings.
// Channel layout, MSB first: {link_active, flit_valid, vc_idx, head, tail, data}.
package nic_flit_injector_pkg;

  localparam int NUM_VCS           = 2;
  localparam int BUFFER_SIZE       = 8;
  localparam int FLIT_DATA_WIDTH   = 64;
  localparam int ROUTER_ADDR_WIDTH = 4;
  localparam int MAX_PKT_LEN       = 4;

  localparam int VC_IDX_WIDTH   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int PKT_LEN_WIDTH  = $clog2(MAX_PKT_LEN + 1);
  localparam int CREDITS_PER_VC = BUFFER_SIZE / NUM_VCS;
  localparam int CREDIT_WIDTH   = $clog2(CREDITS_PER_VC + 1);
  localparam int TS_WIDTH       = 32;

  // flit_ctrl covers {vc_idx, head, tail}; flit_valid and link_active sit above it
  localparam int FLIT_CTRL_WIDTH = 2 + VC_IDX_WIDTH;
  localparam int FLOW_CTRL_WIDTH = 1 + VC_IDX_WIDTH;
  localparam int CHANNEL_WIDTH   = 2 + FLIT_CTRL_WIDTH + FLIT_DATA_WIDTH;

  localparam int DATA_LSB  = 0;
  localparam int TAIL_POS  = FLIT_DATA_WIDTH;
  localparam int HEAD_POS  = TAIL_POS + 1;
  localparam int VC_LSB    = HEAD_POS + 1;
  localparam int VALID_POS = VC_LSB + VC_IDX_WIDTH;
  localparam int LINK_POS  = VALID_POS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // Zero-length descriptors become single-flit packets; oversize ones are clamped.
  function automatic logic [PKT_LEN_WIDTH-1:0] eff_len(input logic [PKT_LEN_WIDTH-1:0] len);
    if (len == '0)
      return PKT_LEN_WIDTH'(1);
    else if (len > PKT_LEN_WIDTH'(MAX_PKT_LEN))
      return PKT_LEN_WIDTH'(MAX_PKT_LEN);
    else
      return len;
  endfunction

endpackage

// File: rtl/nic_flit_injector_credit.sv
// Per-VC credit counter: resets full, inc/dec in the same cycle cancel, inc at full saturates and flags overflow.
// overflow is combinational so the owner can latch it on the same edge the bad credit arrives.
module nic_credit_counter
  import nic_flit_injector_pkg::*;
#(
  parameter int MAX_CREDITS = CREDITS_PER_VC,
  parameter int W           = CREDIT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] FULL = W'(MAX_CREDITS);

  assign overflow = inc && !dec && (count == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FULL;
    end else if (inc && !dec) begin
      if (count != FULL)
        count <= count + W'(1);
    end else if (dec && !inc) begin
      if (count != '0)
        count <= count - W'(1);
    end
  end

endmodule

// File: rtl/nic_flit_injector.sv
// Router injection-port transmitter: descriptor + body stream in, head/body/tail flits out, per-VC credits; 1-cycle
// accept-to-head latency, stalls (valid=0) without credit. NIC_INJ_TIMESTAMP_EN stamps head flits with a cycle count.
module nic_flit_injector
  import nic_flit_injector_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [ROUTER_ADDR_WIDTH-1:0] pkt_dest,
  input  logic [VC_IDX_WIDTH-1:0]      pkt_vc,
  input  logic [PKT_LEN_WIDTH-1:0]     pkt_len,
  input  logic                         body_valid,
  output logic                         body_ready,
  input  logic [FLIT_DATA_WIDTH-1:0]   body_data,
  output logic [CHANNEL_WIDTH-1:0]     channel_out,
  input  logic [FLOW_CTRL_WIDTH-1:0]   flow_ctrl_in,
  output logic                         error
);

  state_t                         state;
  logic                           link_active;
  logic [CHANNEL_WIDTH-2:0]       flit_q;
  logic [VC_IDX_WIDTH-1:0]        cur_vc;
  logic [ROUTER_ADDR_WIDTH-1:0]   cur_dest;
  logic [PKT_LEN_WIDTH-1:0]       cur_len;
  logic [PKT_LEN_WIDTH-1:0]       remaining;
  logic [CREDIT_WIDTH-1:0]        credits [NUM_VCS];
  logic [NUM_VCS-1:0]             inc;
  logic [NUM_VCS-1:0]             dec;
  logic [NUM_VCS-1:0]             ovf;
  logic [FLIT_DATA_WIDTH-1:0]     head_data;
  logic                           credit_valid;
  logic [VC_IDX_WIDTH-1:0]        credit_vc;
  logic                           credit_ok;
  logic                           send_head;
  logic                           send_body;
  logic                           send;
  logic                           accept;

  assign credit_valid = flow_ctrl_in[FLOW_CTRL_WIDTH-1];
  assign credit_vc    = flow_ctrl_in[VC_IDX_WIDTH-1:0];

  assign credit_ok  = (credits[cur_vc] != '0);
  assign send_head  = (state == ST_HEAD) && credit_ok;
  assign send_body  = (state == ST_BODY) && credit_ok && body_valid;
  assign send       = send_head || send_body;
  assign body_ready = (state == ST_BODY) && credit_ok;
  assign pkt_ready  = link_active && (state == ST_IDLE);
  assign accept     = pkt_valid && pkt_ready;

  assign channel_out = {link_active, flit_q};

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
    assign inc[v] = credit_valid && (credit_vc == VC_IDX_WIDTH'(v));
    assign dec[v] = send && (cur_vc == VC_IDX_WIDTH'(v));

    nic_credit_counter u_credit (
      .clk      (clk),
      .rst_n    (reset),
      .inc      (inc[v]),
      .dec      (dec[v]),
      .count    (credits[v]),
      .overflow (ovf[v])
    );
  end

`ifdef NIC_INJ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ts_count <= '0;
    else
      ts_count <= ts_count + TS_WIDTH'(1);
  end
`endif

  always_comb begin
    head_data = '0;
    head_data[ROUTER_ADDR_WIDTH-1:0] = cur_dest;
    head_data[ROUTER_ADDR_WIDTH +: PKT_LEN_WIDTH] = cur_len;
`ifdef NIC_INJ_TIMESTAMP_EN
    head_data[FLIT_DATA_WIDTH-1 -: TS_WIDTH] = ts_count;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      link_active <= 1'b0;
      flit_q      <= '0;
      error       <= 1'b0;
      cur_vc      <= '0;
      cur_dest    <= '0;
      cur_len     <= '0;
      remaining   <= '0;
    end else begin
      link_active <= 1'b1;
      error       <= error || (|ovf) || (accept && (pkt_len == '0));

      // Idle link cycles carry an all-zero flit
      flit_q <= '0;
      if (send) begin
        flit_q[VALID_POS]               <= 1'b1;
        flit_q[VC_LSB +: VC_IDX_WIDTH]  <= cur_vc;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_dest <= pkt_dest;
            cur_vc   <= pkt_vc;
            cur_len  <= eff_len(pkt_len);
            state    <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (credit_ok) begin
            flit_q[HEAD_POS]                      <= 1'b1;
            flit_q[TAIL_POS]                      <= (cur_len <= PKT_LEN_WIDTH'(1));
            flit_q[DATA_LSB +: FLIT_DATA_WIDTH]   <= head_data;
            remaining <= cur_len - PKT_LEN_WIDTH'(1);
            state     <= (cur_len > PKT_LEN_WIDTH'(1)) ? ST_BODY : ST_IDLE;
          end
        end
        ST_BODY: begin
          if (send_body) begin
            flit_q[TAIL_POS]                      <= (remaining == PKT_LEN_WIDTH'(1));
            flit_q[DATA_LSB +: FLIT_DATA_WIDTH]   <= body_data;
            remaining <= remaining - PKT_LEN_WIDTH'(1);
            if (remaining == PKT_LEN_WIDTH'(1))
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_flit_injector.sv
// Directed bench for nic_flit_injector: table of single packets plus hand sequences for credit and reset corners.
module tb_nic_flit_injector;

  logic        clk;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dest;
  logic [0:0]  pkt_vc;
  logic [2:0]  pkt_len;
  logic        body_valid;
  logic        body_ready;
  logic [63:0] body_data;
  logic [68:0] channel_out;
  logic [1:0]  flow_ctrl_in;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic        f_link, f_valid, f_vc, f_head, f_tail;
  logic [63:0] f_data;
  assign f_data  = channel_out[63:0];
  assign f_tail  = channel_out[64];
  assign f_head  = channel_out[65];
  assign f_vc    = channel_out[66];
  assign f_valid = channel_out[67];
  assign f_link  = channel_out[68];

  nic_flit_injector dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_dest     (pkt_dest),
    .pkt_vc       (pkt_vc),
    .pkt_len      (pkt_len),
    .body_valid   (body_valid),
    .body_ready   (body_ready),
    .body_data    (body_data),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NIC_INJ_TIMESTAMP_EN
  logic [31:0] cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic ret_credits(input logic vc, input int n);
    for (int i = 0; i < n; i++) begin
      flow_ctrl_in = {1'b1, vc};
      tick();
    end
    flow_ctrl_in = 2'b00;
  endtask

  task automatic accept_pkt(input logic [3:0] dest, input logic vc, input logic [2:0] len, input string tag);
    int n;
    pkt_dest  = dest;
    pkt_vc    = vc;
    pkt_len   = len;
    pkt_valid = 1'b1;
    n = 0;
    while (!pkt_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, 69'(n < 20), 69'(1));
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic run_pkt(input logic [3:0] dest, input logic vc, input logic [2:0] len,
                         input int nflits, input logic exp_err, input logic do_ret, input string tag);
    int n;
    logic [63:0] exp_data;
    accept_pkt(dest, vc, len, tag);
    n = 0;
    while (!f_valid && n < 20) begin
      tick();
      n++;
    end
    exp_data      = '0;
    exp_data[3:0] = dest;
    exp_data[6:4] = 3'(nflits);
`ifdef NIC_INJ_TIMESTAMP_EN
    exp_data[63:32] = cyc - 32'd1;
`endif
    chk({tag, "_head_vld"},  69'(f_valid), 69'(1));
    chk({tag, "_head_link"}, 69'(f_link),  69'(1));
    chk({tag, "_head_flag"}, 69'(f_head),  69'(1));
    chk({tag, "_head_tail"}, 69'(f_tail),  69'(nflits == 1));
    chk({tag, "_head_vc"},   69'(f_vc),    69'(vc));
    chk({tag, "_head_data"}, 69'(f_data),  69'(exp_data));
    for (int i = 1; i < nflits; i++) begin
      body_data  = 64'hB0D0_0000_0000_0000 | (64'(dest) << 8) | 64'(i);
      body_valid = 1'b1;
      tick();
      n = 0;
      while (!f_valid && n < 20) begin
        tick();
        n++;
      end
      chk({tag, "_body_vld"},  69'(f_valid), 69'(1));
      chk({tag, "_body_head"}, 69'(f_head),  69'(0));
      chk({tag, "_body_tail"}, 69'(f_tail),  69'(i == nflits - 1));
      chk({tag, "_body_data"}, 69'(f_data),  69'(body_data));
    end
    body_valid = 1'b0;
    chk({tag, "_error"}, 69'(error), 69'(exp_err));
    if (do_ret) ret_credits(vc, nflits);
  endtask

  typedef struct {
    logic [3:0] dest;
    logic       vc;
    logic [2:0] len;
    int         nflits;
    logic       err;
    string      tag;
  } vec_t;

  vec_t tbl [5];
  int   cnt;

  initial begin
    tbl[0] = '{dest: 4'h5, vc: 1'b1, len: 3'd3, nflits: 3, err: 1'b0, tag: "v0_len3"};
    tbl[1] = '{dest: 4'hA, vc: 1'b0, len: 3'd1, nflits: 1, err: 1'b0, tag: "v1_len1"};
    tbl[2] = '{dest: 4'h3, vc: 1'b0, len: 3'd7, nflits: 4, err: 1'b0, tag: "v2_clamp"};
    tbl[3] = '{dest: 4'hF, vc: 1'b1, len: 3'd4, nflits: 4, err: 1'b0, tag: "v3_len4"};
    tbl[4] = '{dest: 4'h9, vc: 1'b0, len: 3'd0, nflits: 1, err: 1'b1, tag: "v4_len0"};

    reset = 1'b0; pkt_valid = 1'b0; pkt_dest = '0; pkt_vc = '0; pkt_len = '0;
    body_valid = 1'b0; body_data = '0; flow_ctrl_in = 2'b00;

    // reset state and link bring-up
    tick();
    tick();
    chk("rst_channel",   channel_out,      69'(0));
    chk("rst_pkt_ready", 69'(pkt_ready),   69'(0));
    chk("rst_body_rdy",  69'(body_ready),  69'(0));
    chk("rst_error",     69'(error),       69'(0));
    reset = 1'b1;
    #1;
    chk("link_pre_edge", 69'(f_link), 69'(0));
    tick();
    chk("link_active",   69'(f_link),    69'(1));
    chk("idle_ready",    69'(pkt_ready), 69'(1));
    chk("idle_valid",    69'(f_valid),   69'(0));
    chk("idle_error",    69'(error),     69'(0));

    for (int k = 0; k < 5; k++)
      run_pkt(tbl[k].dest, tbl[k].vc, tbl[k].len, tbl[k].nflits, tbl[k].err, 1'b1, tbl[k].tag);

    // hand-timed 3-flit packet on vc1, then prove exactly one vc1 credit is left
    do_reset();
    accept_pkt(4'b0101, 1'b1, 3'd3, "t2");
    body_valid = 1'b1;
    body_data  = 64'hA;
    tick();
    chk("t2_head_vld",  69'(f_valid),    69'(1));
    chk("t2_head_tail", 69'(f_tail),     69'(0));
    chk("t2_head_vc",   69'(f_vc),       69'(1));
    chk("t2_head_data", 69'(f_data),     69'(64'h35));
    chk("t2_body_rdy",  69'(body_ready), 69'(1));
    tick();
    chk("t2_b0_data",   69'(f_data),     69'(64'hA));
    chk("t2_b0_tail",   69'(f_tail),     69'(0));
    body_data = 64'hB;
    tick();
    chk("t2_b1_data",   69'(f_data),     69'(64'hB));
    chk("t2_b1_tail",   69'(f_tail),     69'(1));
    chk("t2_b1_vc",     69'(f_vc),       69'(1));
    body_valid = 1'b0;
    chk("t2_ready_after_tail", 69'(pkt_ready), 69'(1));
    pkt_dest = 4'h5; pkt_vc = 1'b1; pkt_len = 3'd2; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t2_gap_cycle", 69'(f_valid), 69'(0));
    tick();
    chk("t2_p2_head",   69'(f_valid),    69'(1));
    chk("t2_no_credit", 69'(body_ready), 69'(0));
    body_valid = 1'b1;
    body_data  = 64'hC;
    cnt = 0;
    repeat (3) begin
      tick();
      if (f_valid) cnt++;
    end
    chk("t2_stall", 69'(cnt), 69'(0));
    flow_ctrl_in = 2'b11;
    tick();
    flow_ctrl_in = 2'b00;
    chk("t2_credit_rdy", 69'(body_ready), 69'(1));
    tick();
    chk("t2_p2_tail",   69'(f_valid && f_tail), 69'(1));
    body_valid = 1'b0;
    ret_credits(1'b1, 4);

    // five single-flit packets on vc0 with no credit return
    cnt = 0;
    for (int p = 0; p < 5; p++) begin
      int n;
      pkt_dest = 4'h2; pkt_vc = 1'b0; pkt_len = 3'd1; pkt_valid = 1'b1;
      n = 0;
      while (!pkt_ready && n < 20) begin
        tick();
        if (f_valid) cnt++;
        n++;
      end
      tick();
      if (f_valid) cnt++;
    end
    pkt_valid = 1'b0;
    repeat (10) begin
      tick();
      if (f_valid) cnt++;
    end
    chk("t3_four_sent", 69'(cnt),       69'(4));
    chk("t3_held",      69'(pkt_ready), 69'(0));
    flow_ctrl_in = 2'b10;
    tick();
    flow_ctrl_in = 2'b00;
    chk("t3_not_yet",   69'(f_valid), 69'(0));
    tick();
    chk("t3_fifth",     69'(f_valid && f_head && f_tail), 69'(1));
    ret_credits(1'b0, 4);

    // same-cycle send and return on vc0 at credits=2, then overflow at full
    accept_pkt(4'h7, 1'b0, 3'd4, "t4");
    tick();
    chk("t4_head", 69'(f_valid && f_head), 69'(1));
    body_valid = 1'b1;
    body_data  = 64'h1;
    tick();
    chk("t4_b1", 69'(f_valid), 69'(1));
    flow_ctrl_in = 2'b10;
    body_data    = 64'h2;
    tick();
    flow_ctrl_in = 2'b00;
    chk("t4_b2", 69'(f_valid), 69'(1));
    body_data = 64'h3;
    tick();
    chk("t4_b3_tail", 69'(f_valid && f_tail), 69'(1));
    body_valid = 1'b0;
    ret_credits(1'b0, 3);
    chk("t4_full_no_err", 69'(error), 69'(0));
    ret_credits(1'b0, 1);
    chk("t4_overflow_err", 69'(error), 69'(1));
    run_pkt(4'h7, 1'b0, 3'd4, 4, 1'b1, 1'b0, "t4_sat");
    accept_pkt(4'h7, 1'b0, 3'd1, "t4_extra");
    cnt = 0;
    repeat (6) begin
      tick();
      if (f_valid) cnt++;
    end
    chk("t4_saturated", 69'(cnt), 69'(0));

    // reset in the middle of a packet
    do_reset();
    accept_pkt(4'hC, 1'b1, 3'd4, "t5");
    body_valid = 1'b1;
    body_data  = 64'h55;
    tick();
    tick();
    chk("t5_mid_body", 69'(f_valid), 69'(1));
    reset = 1'b0;
    #1;
    chk("t5_chan_zero", channel_out,     69'(0));
    chk("t5_pkt_rdy0",  69'(pkt_ready),  69'(0));
    chk("t5_body_rdy0", 69'(body_ready), 69'(0));
    body_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_idle",  69'(pkt_ready), 69'(1));
    chk("t5_error", 69'(error),     69'(0));
    run_pkt(4'hC, 1'b1, 3'd4, 4, 1'b0, 1'b0, "t5_vc1");
    run_pkt(4'h1, 1'b0, 3'd4, 4, 1'b0, 1'b0, "t5_vc0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
